// File: rtl/pixel_pkg.sv
// Shared constants and types for the pixel compositor: palette, layer config record, pipeline depth.
package pixel_pkg;

  localparam int PIPE_LAT = 3;
  localparam int COORD_W  = 10;

  localparam logic [11:0] COLOR_BLACK   = 12'h000;
  localparam logic [11:0] COLOR_WHITE   = 12'hFFF;
  localparam logic [11:0] COLOR_RED     = 12'hF00;
  localparam logic [11:0] COLOR_GREEN   = 12'h0F0;
  localparam logic [11:0] COLOR_BLUE    = 12'h00F;
  localparam logic [11:0] COLOR_MAGENTA = 12'hF0F;

  localparam logic [11:0] TEXT_COLOR_DEF = COLOR_BLACK;
  localparam logic [11:0] BG_COLOR_DEF   = COLOR_WHITE;
  localparam logic [11:0] KEY_COLOR_DEF  = COLOR_MAGENTA;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               en;
  } layer_cfg_t;

endpackage

// File: rtl/pixel_compositor_if.sv
// Layer configuration write port: one strobe carrying target layer, position and enable.
interface pixel_compositor_if #(
  parameter int NUM_LAYERS   = 4,
  parameter int SCREEN_WIDTH = 10
);
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic                    cfg_valid;
  logic [LW-1:0]           cfg_layer;
  logic [SCREEN_WIDTH-1:0] cfg_x;
  logic [SCREEN_WIDTH-1:0] cfg_y;
  logic                    cfg_en;

  modport master (output cfg_valid, cfg_layer, cfg_x, cfg_y, cfg_en);
  modport slave  (input  cfg_valid, cfg_layer, cfg_x, cfg_y, cfg_en);
endinterface

// File: rtl/hex_font_rom.sv
// Combinational 8x8 hex-digit glyph ROM; other power-of-2 glyph sizes sample the 8x8 grid.
module hex_font_rom #(
  parameter  int FONT_WIDTH = 8,
  localparam int FW_LOG     = (FONT_WIDTH > 1) ? $clog2(FONT_WIDTH) : 1
) (
  input  logic [3:0]        nibble,
  input  logic [FW_LOG-1:0] row,
  input  logic [FW_LOG-1:0] col,
  output logic              glyph_bit
);

  logic [63:0] glyph;
  logic [2:0]  row8;
  logic [2:0]  col8;

  always_comb begin
    row8 = 3'((int'(row) * 8) / FONT_WIDTH);
    col8 = 3'((int'(col) * 8) / FONT_WIDTH);
  end

  // Top byte is glyph row 0; MSB of each byte is the leftmost column.
  always_comb begin
    glyph = '0;
    case (nibble)
      4'h0: glyph = 64'h3C666E7666663C00;
      4'h1: glyph = 64'h1838181818187E00;
      4'h2: glyph = 64'h3C66060C30607E00;
      4'h3: glyph = 64'h3C66061C06663C00;
      4'h4: glyph = 64'h0C1C3C6C7E0C0C00;
      4'h5: glyph = 64'h7E607C0606663C00;
      4'h6: glyph = 64'h3C607C6666663C00;
      4'h7: glyph = 64'h7E060C1830303000;
      4'h8: glyph = 64'h3C66663C66663C00;
      4'h9: glyph = 64'h3C66663E060C3800;
      4'hA: glyph = 64'h183C66667E666600;
      4'hB: glyph = 64'h7C66667C66667C00;
      4'hC: glyph = 64'h3C66606060663C00;
      4'hD: glyph = 64'h786C6666666C7800;
      4'hE: glyph = 64'h7E60607C60607E00;
      4'hF: glyph = 64'h7E60607C60606000;
      default: glyph = '0;
    endcase
  end

  assign glyph_bit = glyph[~{row8, col8}];

endmodule

// File: rtl/pixel_compositor.sv
// Three-stage pixel compositor: hex debug text over colour-keyed sprite layers over a background,
// with layer positions committed only at frame start.
module pixel_compositor
  import pixel_pkg::*;
#(
  parameter int PIXEL_WIDTH  = 12,
  parameter int SCREEN_WIDTH = COORD_W,
  parameter int NUM_LAYERS   = 4,
  parameter int LAYER_W      = 32,
  parameter int LAYER_H      = 32,
  parameter int SEQ_NUM      = 16,
  parameter int SEQ_DIGITS   = 4,
  parameter int FONT_WIDTH   = 8,
  parameter int SEQ_INTERVAL = 5,
  parameter logic [PIXEL_WIDTH-1:0] BG_COLOR   = BG_COLOR_DEF,
  parameter logic [PIXEL_WIDTH-1:0] TEXT_COLOR = TEXT_COLOR_DEF,
  parameter logic [PIXEL_WIDTH-1:0] KEY_COLOR  = KEY_COLOR_DEF
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst,
  input  logic                               video_on,
  input  logic [SCREEN_WIDTH-1:0]            x,
  input  logic [SCREEN_WIDTH-1:0]            y,
  input  logic                               hsync_in,
  input  logic                               vsync_in,
  input  logic                               frame_start,
  pixel_compositor_if.slave                  cfg,
  input  logic [SEQ_NUM*SEQ_DIGITS*4-1:0]    debug_val,
  output logic [NUM_LAYERS*SCREEN_WIDTH-1:0] layer_x_rom,
  output logic [NUM_LAYERS*SCREEN_WIDTH-1:0] layer_y_rom,
  input  logic [NUM_LAYERS*PIXEL_WIDTH-1:0]  layer_rgb,
  output logic [PIXEL_WIDTH-1:0]             rgb,
  output logic                               hsync_out,
  output logic                               vsync_out,
  output logic                               video_on_out
);

  localparam int FW_LOG    = (FONT_WIDTH > 1) ? $clog2(FONT_WIDTH) : 1;
  localparam int ROW_PITCH = FONT_WIDTH + SEQ_INTERVAL;
  localparam logic [SCREEN_WIDTH:0] LAYER_W_E = (SCREEN_WIDTH+1)'(LAYER_W);
  localparam logic [SCREEN_WIDTH:0] LAYER_H_E = (SCREEN_WIDTH+1)'(LAYER_H);

  layer_cfg_t shadow [NUM_LAYERS];
  layer_cfg_t active [NUM_LAYERS];

  // Non-blocking update makes a coincident write miss this commit and land next frame.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (frame_start) begin
        for (int i = 0; i < NUM_LAYERS; i++) active[i] <= shadow[i];
      end
      if (cfg.cfg_valid && (int'(cfg.cfg_layer) < NUM_LAYERS)) begin
        shadow[cfg.cfg_layer] <= '{x: cfg.cfg_x, y: cfg.cfg_y, en: cfg.cfg_en};
      end
    end
  end

  logic [NUM_LAYERS-1:0]   hit_c;
  logic [SCREEN_WIDTH-1:0] lx_c [NUM_LAYERS];
  logic [SCREEN_WIDTH-1:0] ly_c [NUM_LAYERS];

  // Compare one bit wider than the screen so a window at the right/bottom edge never wraps to 0.
  always_comb begin
    hit_c = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      hit_c[i] = active[i].en
              && ({1'b0, x} >= {1'b0, active[i].x})
              && ({1'b0, x} <  ({1'b0, active[i].x} + LAYER_W_E))
              && ({1'b0, y} >= {1'b0, active[i].y})
              && ({1'b0, y} <  ({1'b0, active[i].y} + LAYER_H_E));
      lx_c[i] = hit_c[i] ? (x - active[i].x) : '0;
      ly_c[i] = hit_c[i] ? (y - active[i].y) : '0;
    end
  end

  logic              text_hit_c;
  logic [3:0]        nibble_c;
  logic [FW_LOG-1:0] grow_c;
  logic [FW_LOG-1:0] gcol_c;

  always_comb begin
    text_hit_c = 1'b0;
    nibble_c   = '0;
    grow_c     = '0;
    gcol_c     = x[FW_LOG-1:0];
    for (int k = 0; k < SEQ_NUM; k++) begin
      if ((int'(y) >= k*ROW_PITCH) && (int'(y) < k*ROW_PITCH + FONT_WIDTH)
          && (int'(x) < SEQ_DIGITS*FONT_WIDTH)) begin
        text_hit_c = 1'b1;
        grow_c     = FW_LOG'(int'(y) - k*ROW_PITCH);
        nibble_c   = debug_val[(k*SEQ_DIGITS + SEQ_DIGITS - 1 - (int'(x) >> FW_LOG))*4 +: 4];
      end
    end
  end

  logic [NUM_LAYERS-1:0] hit1;
  logic                  text_hit1;
  logic [3:0]            nibble1;
  logic [FW_LOG-1:0]     grow1;
  logic [FW_LOG-1:0]     gcol1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hit1        <= '0;
      text_hit1   <= 1'b0;
      nibble1     <= '0;
      grow1       <= '0;
      gcol1       <= '0;
      layer_x_rom <= '0;
      layer_y_rom <= '0;
    end else begin
      hit1      <= hit_c;
      text_hit1 <= text_hit_c;
      nibble1   <= nibble_c;
      grow1     <= grow_c;
      gcol1     <= gcol_c;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        layer_x_rom[i*SCREEN_WIDTH +: SCREEN_WIDTH] <= lx_c[i];
        layer_y_rom[i*SCREEN_WIDTH +: SCREEN_WIDTH] <= ly_c[i];
      end
    end
  end

  logic glyph_c;

  hex_font_rom #(.FONT_WIDTH(FONT_WIDTH)) u_font (
    .nibble    (nibble1),
    .row       (grow1),
    .col       (gcol1),
    .glyph_bit (glyph_c)
  );

  logic [NUM_LAYERS-1:0] hit2;
  logic                  text_hit2;
  logic                  glyph2;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hit2      <= '0;
      text_hit2 <= 1'b0;
      glyph2    <= 1'b0;
    end else begin
      hit2      <= hit1;
      text_hit2 <= text_hit1;
      glyph2    <= glyph_c;
    end
  end

  logic [PIPE_LAT-1:0] vid_d;
  logic [PIPE_LAT-1:0] hs_d;
  logic [PIPE_LAT-1:0] vs_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vid_d <= '0;
      hs_d  <= '1;
      vs_d  <= '1;
    end else begin
      vid_d <= {vid_d[PIPE_LAT-2:0], video_on};
      hs_d  <= {hs_d[PIPE_LAT-2:0],  hsync_in};
      vs_d  <= {vs_d[PIPE_LAT-2:0],  vsync_in};
    end
  end

  assign video_on_out = vid_d[PIPE_LAT-1];
  assign hsync_out    = hs_d[PIPE_LAT-1];
  assign vsync_out    = vs_d[PIPE_LAT-1];

  logic [PIXEL_WIDTH-1:0] pix_c;

  // Highest index applied first so the lowest-index opaque layer wins.
  always_comb begin
    pix_c = BG_COLOR;
    for (int i = NUM_LAYERS-1; i >= 0; i--) begin
      if (hit2[i] && (layer_rgb[i*PIXEL_WIDTH +: PIXEL_WIDTH] != KEY_COLOR)) begin
        pix_c = layer_rgb[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
    end
    if (text_hit2 && glyph2) pix_c = TEXT_COLOR;
    if (!vid_d[PIPE_LAT-2])  pix_c = '0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) rgb <= '0;
    else         rgb <= pix_c;
  end

endmodule
